ahb3lite_gpio: RTL and testbench
================================

// Module: ahb3lite_gpio
// PURPOSE
//  Parametrised AHB3-Lite slave GPIO port, replacing the hard-wired LED/push-button glue at SoC top.
//  Sits behind one slave port of ahb3lite_interconnect, beside the ROM/RAM slaves.
//  Drives G_WIDTH outputs (LEDs), samples G_WIDTH async inputs (buttons), raises a rising-edge IRQ to irq_i of the M0.
// PARAMETERS
//  G_WIDTH          8      number of GPIO out/in pins, 1..32
//  G_SYNC_STAGES    2      input synchroniser depth, >=2
//  G_DEBOUNCE_CYC   10000  stable cycles required before input update (only with GPIO_DEBOUNCE_EN)
//  HADDR_SIZE       32     AHB address width
//  HDATA_SIZE       32     AHB data width, fixed 32
// PORTS
//  hclk_i       in   1           bus clock, single clock domain
//  hreset_i     in   1           asynchronous, active-high reset
//  hsel_i       in   1           slave select
//  haddr_i      in   HADDR_SIZE  address; only [4:0] decoded
//  hwdata_i     in   32          write data (data phase)
//  hrdata_o     out  32          read data (data phase)
//  hwrite_i     in   1           1=write
//  hsize_i      in   3           0=byte,1=half,2=word
//  htrans_i     in   2           IDLE/BUSY/NONSEQ/SEQ
//  hready_i     in   1           bus-wide HREADY
//  hreadyout_o  out  1           always 1 (zero wait state)
//  hresp_o      out  1           always 0 (OKAY)
//  gpio_o       out  G_WIDTH     output register
//  gpio_i       in   G_WIDTH     asynchronous inputs
//  irq_o        out  1           registered |(IRQ_STAT & IRQ_EN)
// BEHAVIOUR
//  Reset: DATA_OUT, IRQ_EN, IRQ_STAT, sync/debounce state, edge history, irq_o = 0; hrdata_o=0.
//  Address phase accepted when hsel_i & htrans_i[1] & hready_i; haddr[4:2], hwrite, byte lanes latched.
//  Byte lanes from hsize/haddr[1:0]: byte->1 lane, half->2 lanes (haddr[1]), word->all 4.
//  Write applied at end of data phase (next rising edge after address phase) using hwdata_i, lanes only;
//  bits >= G_WIDTH ignored. Back-to-back transfers supported every cycle.
//  Read: hrdata_o combinational from latched offset in data phase; bits >= G_WIDTH read 0.
//  Register map (offset): 0x00 DATA_OUT RW | 0x04 SET W1S | 0x08 CLR W1C | 0x0C TGL W1T
//   | 0x10 DATA_IN RO | 0x14 IRQ_EN RW | 0x18 IRQ_STAT RW1C | 0x1C reserved RAZ/WI.
//  SET/CLR/TGL read back DATA_OUT. Writes to DATA_IN ignored.
//  Input path: G_SYNC_STAGES flops -> (debounce) -> DATA_IN; edge = DATA_IN & ~DATA_IN_q.
//  IRQ_STAT[i] set on edge[i]; cleared by writing 1; simultaneous edge and clear -> stays set.
//  irq_o updates one cycle after IRQ_STAT/IRQ_EN change. Latency pin->DATA_IN = G_SYNC_STAGES+1 cycles.
//  Reset asserted mid-transfer: pending write discarded, data-phase state cleared.
//  IDLE/BUSY or hsel_i=0: no state change; hready_i=0: address not latched.
// CONFIGURATION
//  GPIO_DEBOUNCE_EN defined: per-pin counter; DATA_IN[i] updates only after synced input differs
//   from DATA_IN[i] for G_DEBOUNCE_CYC consecutive cycles; any return resets counter to 0.
//  Not defined: DATA_IN = synchroniser output directly; G_DEBOUNCE_CYC unused, no counters built.
// STRUCTURE
//  gpio_pkg: register offset enum, HTRANS/HSIZE constants, byte-lane decode function.
//  Sub-module gpio_debounce (one pin, generate-instanced G_WIDTH times under GPIO_DEBOUNCE_EN).
// TESTING
//  Word write 0xA5 to 0x00, read 0x00 -> 0x000000A5, gpio_o=0xA5; hreadyout_o=1, hresp_o=0 throughout.
//  DATA_OUT=0xF0; write 0x0F to SET, 0x30 to CLR, 0x81 to TGL -> gpio_o=0x4E after three cycles.
//  Byte write 0x3C at 0x01 with G_WIDTH=16 -> DATA_OUT=0x3C00, low byte untouched.
//  IRQ_EN=0x01, gpio_i[0] 0->1 -> IRQ_STAT=0x01, irq_o=1; W1C 0x01 same cycle as new edge -> stays 1.
//  Debounce EN, G_DEBOUNCE_CYC=4: glitch of 3 cycles -> DATA_IN unchanged; 4+ cycles -> updates.
//  Assert hreset_i during write data phase -> all registers 0, write lost; NONSEQ after release works.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: register map, AHB transfer constants and byte-lane decode for ahb3lite_gpio
package gpio_pkg;
  typedef enum logic [2:0] {
    REG_DOUT = 3'd0,
    REG_SET  = 3'd1,
    REG_CLR  = 3'd2,
    REG_TGL  = 3'd3,
    REG_DIN  = 3'd4,
    REG_IEN  = 3'd5,
    REG_IST  = 3'd6,
    REG_RSV  = 3'd7
  } reg_e;
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;
  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] addr);
    return size == HSIZE_BYTE ? 4'b0001 << addr :
           size == HSIZE_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: single-pin filter; output follows input only after CYC consecutive differing cycles
module gpio_debounce #(
  parameter int CYC = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  localparam int CW = $clog2(CYC + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (d == q) begin
      cnt <= '0;
    end else if (cnt == CW'(CYC - 1)) begin
      q   <= d;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/ahb3lite_gpio.sv
// ahb3lite_gpio: zero-wait-state AHB3-Lite GPIO slave with W1S/W1C/W1T outputs and rising-edge IRQ.
// Optional per-pin input debounce when GPIO_DEBOUNCE_EN is defined.
module ahb3lite_gpio
  import gpio_pkg::*;
#(
  parameter int G_WIDTH        = 8,
  parameter int G_SYNC_STAGES  = 2,
  parameter int G_DEBOUNCE_CYC = 10000,
  parameter int HADDR_SIZE     = 32,
  parameter int HDATA_SIZE     = 32
) (
  input  logic                  hclk_i,
  input  logic                  hreset_i,
  input  logic                  hsel_i,
  input  logic [HADDR_SIZE-1:0] haddr_i,
  input  logic [HDATA_SIZE-1:0] hwdata_i,
  output logic [HDATA_SIZE-1:0] hrdata_o,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [1:0]            htrans_i,
  input  logic                  hready_i,
  output logic                  hreadyout_o,
  output logic                  hresp_o,
  output logic [G_WIDTH-1:0]    gpio_o,
  input  logic [G_WIDTH-1:0]    gpio_i,
  output logic                  irq_o
);
  logic acc, dp_act, dp_wr;
  reg_e dp_off;
  logic [3:0] dp_be;
  logic [31:0] lane_m;
  logic [G_WIDTH-1:0] wmask, wbits, dout, dout_n, ien, ien_n, ist, ist_n, din, din_q, rise, rd;
  logic [G_SYNC_STAGES-1:0][G_WIDTH-1:0] sync;
  logic wr_dout, wr_set, wr_clr, wr_tgl, wr_ien, wr_ist;
  logic unused;
  assign acc = hsel_i & htrans_i[1] & hready_i;
  assign hreadyout_o = 1'b1;
  assign hresp_o = 1'b0;
  assign gpio_o = dout;
  always_ff @(posedge hclk_i or posedge hreset_i)
    if (hreset_i) begin
      dp_act <= 1'b0;
      dp_wr  <= 1'b0;
      dp_off <= REG_DOUT;
      dp_be  <= '0;
    end else begin
      dp_act <= acc;
      dp_wr  <= acc & hwrite_i;
      if (acc) begin
        dp_off <= reg_e'(haddr_i[4:2]);
        dp_be  <= byte_lanes(hsize_i, haddr_i[1:0]);
      end
    end
  assign lane_m = {{8{dp_be[3]}}, {8{dp_be[2]}}, {8{dp_be[1]}}, {8{dp_be[0]}}};
  assign wmask = lane_m[G_WIDTH-1:0];
  assign wbits = hwdata_i[G_WIDTH-1:0] & wmask;
  assign wr_dout = dp_wr & (dp_off == REG_DOUT);
  assign wr_set  = dp_wr & (dp_off == REG_SET);
  assign wr_clr  = dp_wr & (dp_off == REG_CLR);
  assign wr_tgl  = dp_wr & (dp_off == REG_TGL);
  assign wr_ien  = dp_wr & (dp_off == REG_IEN);
  assign wr_ist  = dp_wr & (dp_off == REG_IST);
  always_comb begin
    dout_n = wr_dout ? (dout & ~wmask) | wbits :
             wr_set  ? dout | wbits :
             wr_clr  ? dout & ~wbits :
             wr_tgl  ? dout ^ wbits : dout;
    ien_n  = wr_ien ? (ien & ~wmask) | wbits : ien;
    // a new edge wins over a simultaneous clear
    ist_n  = (ist & ~(wr_ist ? wbits : '0)) | rise;
  end
  always_ff @(posedge hclk_i or posedge hreset_i)
    if (hreset_i) begin
      dout  <= '0;
      ien   <= '0;
      ist   <= '0;
      irq_o <= 1'b0;
      sync  <= '0;
      din_q <= '0;
    end else begin
      dout  <= dout_n;
      ien   <= ien_n;
      ist   <= ist_n;
      irq_o <= |(ist & ien);
      sync  <= {sync[G_SYNC_STAGES-2:0], gpio_i};
      din_q <= din;
    end
`ifdef GPIO_DEBOUNCE_EN
  for (genvar i = 0; i < G_WIDTH; i++) begin : g_db
    gpio_debounce #(.CYC(G_DEBOUNCE_CYC)) u_db (
      .clk(hclk_i),
      .rst(hreset_i),
      .d  (sync[G_SYNC_STAGES-1][i]),
      .q  (din[i])
    );
  end
`else
  always_ff @(posedge hclk_i or posedge hreset_i)
    if (hreset_i) din <= '0;
    else din <= sync[G_SYNC_STAGES-1];
`endif
  assign rise = din & ~din_q;
  always_comb begin
    rd = !dp_act ? '0 :
         (dp_off == REG_DIN) ? din :
         (dp_off == REG_IEN) ? ien :
         (dp_off == REG_IST) ? ist :
         (dp_off == REG_RSV) ? '0 : dout;
    hrdata_o = HDATA_SIZE'(rd);
  end
  assign unused = ^{haddr_i, hwdata_i, hsize_i, htrans_i[0], lane_m};
endmodule

// File: tb/tb_ahb3lite_gpio.sv
// tb_ahb3lite_gpio: directed pipelined AHB stimulus with a read-data scoreboard queue
module tb_ahb3lite_gpio;
  import gpio_pkg::*;
  localparam int W = 16, S = 2, DB = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int EXTRA = DB - 1;
`else
  localparam int EXTRA = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hsel = 1'b0, hwrite = 1'b0, hready = 1'b1;
  logic [31:0] haddr = '0, hwdata = '0, hrdata;
  logic [2:0] hsize = HSIZE_WORD;
  logic [1:0] htrans = HTRANS_IDLE;
  logic hreadyout, hresp, irq;
  logic [W-1:0] gpio_out, gpio_in = '0;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic pend_rd = 1'b0;
  logic [31:0] pend_wd = '0;
  always #5 clk = ~clk;
  ahb3lite_gpio #(.G_WIDTH(W), .G_SYNC_STAGES(S), .G_DEBOUNCE_CYC(DB)) dut (
    .hclk_i(clk), .hreset_i(rst), .hsel_i(hsel), .haddr_i(haddr), .hwdata_i(hwdata),
    .hrdata_o(hrdata), .hwrite_i(hwrite), .hsize_i(hsize), .htrans_i(htrans), .hready_i(hready),
    .hreadyout_o(hreadyout), .hresp_o(hresp), .gpio_o(gpio_out), .gpio_i(gpio_in), .irq_o(irq)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic bus(input logic sel, input logic [1:0] tr, input logic rdy, input logic w,
                     input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                     input logic [31:0] ex);
    @(negedge clk);
    chk("hreadyout", {31'b0, hreadyout}, 32'd1);
    chk("hresp", {31'b0, hresp}, 32'd0);
    if (pend_rd) chk("rdata", hrdata, exp_q.pop_front());
    hwdata = pend_wd;
    hsel = sel; htrans = tr; hready = rdy; hwrite = w; haddr = a; hsize = sz;
    pend_rd = sel & tr[1] & rdy & ~w;
    if (pend_rd) exp_q.push_back(ex);
    pend_wd = wd;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz = HSIZE_WORD);
    bus(1'b1, HTRANS_NONSEQ, 1'b1, 1'b1, a, sz, d, '0);
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] ex);
    bus(1'b1, HTRANS_NONSEQ, 1'b1, 1'b0, a, HSIZE_WORD, '0, ex);
  endtask
  task automatic idle();
    bus(1'b0, HTRANS_IDLE, 1'b1, 1'b0, '0, HSIZE_WORD, '0, '0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio_o", 32'(gpio_out), 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    wr(32'h00, 32'hA5);
    rd(32'h00, 32'hA5);
    idle();
    chk("gpio_a5", 32'(gpio_out), 32'hA5);
    wr(32'h00, 32'hF0);
    wr(32'h04, 32'h0F);
    wr(32'h08, 32'h30);
    wr(32'h0C, 32'h81);
    idle();
    chk("gpio_set_clr_tgl", 32'(gpio_out), 32'h4E);
    rd(32'h04, 32'h4E);
    rd(32'h08, 32'h4E);
    wr(32'h00, 32'h0);
    wr(32'h01, 32'h3C00, HSIZE_BYTE);
    rd(32'h00, 32'h3C00);
    wr(32'h00, 32'h34);
    wr(32'h01, 32'h3C00, HSIZE_BYTE);
    wr(32'h02, 32'hFFFF_0000, HSIZE_HALF);
    rd(32'h00, 32'h3C34);
    bus(1'b0, HTRANS_NONSEQ, 1'b1, 1'b1, 32'h00, HSIZE_WORD, 32'hFFFF, '0);
    bus(1'b1, HTRANS_BUSY, 1'b1, 1'b1, 32'h00, HSIZE_WORD, 32'hFFFF, '0);
    bus(1'b1, HTRANS_NONSEQ, 1'b0, 1'b1, 32'h00, HSIZE_WORD, 32'hFFFF, '0);
    bus(1'b1, HTRANS_NONSEQ, 1'b0, 1'b0, 32'h00, HSIZE_WORD, '0, '0);
    idle();
    rd(32'h00, 32'h3C34);
    wr(32'h00, 32'hFFFF_FFFF);
    rd(32'h00, 32'h0000_FFFF);
    wr(32'h00, 32'h0000_AB77, HSIZE_BYTE);
    rd(32'h00, 32'h0000_FF77);
    wr(32'h10, 32'hFFFF);
    rd(32'h10, 32'h0);
    wr(32'h1C, 32'hFFFF);
    rd(32'h1C, 32'h0);
    wr(32'h14, 32'h1);
    rd(32'h14, 32'h1);
    gpio_in = 16'h0001;
    n = 0;
    while (!irq && n < 20 + EXTRA) begin
      idle();
      n++;
    end
    chk("irq_rise", {31'b0, irq}, 32'd1);
    rd(32'h18, 32'h1);
    rd(32'h10, 32'h1);
    gpio_in = 16'h0003;
    repeat (6 + EXTRA) idle();
    rd(32'h18, 32'h3);
    wr(32'h18, 32'h3);
    idle();
    idle();
    chk("irq_cleared", {31'b0, irq}, 32'd0);
    rd(32'h18, 32'h0);
    gpio_in = 16'h0000;
    repeat (6 + EXTRA) idle();
    rd(32'h18, 32'h0);
    gpio_in = 16'h0001;
    idle();
    idle();
    repeat (EXTRA) idle();
    wr(32'h18, 32'h1);
    idle();
    rd(32'h18, 32'h1);
    idle();
    chk("irq_edge_beats_clear", {31'b0, irq}, 32'd1);
    wr(32'h14, 32'h0);
    idle();
    idle();
    chk("irq_masked", {31'b0, irq}, 32'd0);
    wr(32'h14, 32'h1);
    gpio_in = 16'h0000;
    repeat (6 + EXTRA) idle();
    wr(32'h00, 32'h55);
    @(negedge clk);
    hwdata = pend_wd;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    rst = 1'b1;
    pend_wd = '0;
    pend_rd = 1'b0;
    @(posedge clk) #1;
    chk("rst_mid_gpio", 32'(gpio_out), 32'd0);
    chk("rst_mid_irq", {31'b0, irq}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    rd(32'h00, 32'h0);
    rd(32'h14, 32'h0);
    rd(32'h18, 32'h0);
    wr(32'h00, 32'h66);
    rd(32'h00, 32'h66);
    idle();
    chk("gpio_after_rst", 32'(gpio_out), 32'h66);
`ifdef GPIO_DEBOUNCE_EN
    gpio_in = 16'h0004;
    repeat (3) idle();
    gpio_in = 16'h0000;
    repeat (8) idle();
    rd(32'h10, 32'h0);
    rd(32'h18, 32'h0);
    gpio_in = 16'h0004;
    repeat (10) idle();
    rd(32'h10, 32'h4);
    rd(32'h18, 32'h4);
`endif
    idle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
